// File: rtl/knn_reset_sequencer.sv
// ----------------------------------------------------------------------------
// knn_reset_sequencer
//
// Turns reset requests for the KNN accelerator into clean, timed reset pulses.
// A request is either a rising edge on the PIO level req_in or a software
// write. Each sequence holds knn_reset_n low for RESET_CYCLES cycles and then
// waits SETTLE_CYCLES cycles before it is counted as complete. Status, the
// completion count and a level interrupt are visible on an Avalon-MM slave.
//
// Ports
//   clk          system clock, the only clock
//   reset_n      asynchronous active-low reset
//   req_in       reset request level from the PIO port (asynchronous to clk)
//   address      Avalon word address
//   chipselect   Avalon slave select
//   write_n      Avalon write strobe, active low
//   writedata    Avalon write data
//   readdata     Avalon read data, registered, 1-cycle latency
//   knn_reset_n  active-low reset to the KNN accelerator (registered)
//   busy         high while a sequence is in progress (registered)
//   irq          level interrupt, follows the sticky done bit
//
// Register map
//   0  R {29'b0, overrun, done, busy}         W bit0=1 starts a sequence
//   1  R zero-extended completion count       W ignored
//   2  R 0                                    W bit0=1 clears done,
//                                               bit1=1 clears overrun
//   3  R {SETTLE_CYCLES[15:0], RESET_CYCLES[15:0]}   W ignored
// ----------------------------------------------------------------------------
module knn_reset_sequencer #(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        knn_reset_n,
   output logic        busy,
   output logic        irq
);

   localparam int unsigned TIMER_W = 16;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CFG_W   = 16;

   localparam logic [TIMER_W-1:0] RESET_LOAD  = TIMER_W'(RESET_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [CFG_W-1:0]   RESET_CFG   = CFG_W'(RESET_CYCLES);
   localparam logic [CFG_W-1:0]   SETTLE_CFG  = CFG_W'(SETTLE_CYCLES);

   localparam logic [1:0] ADDR_CTRL  = 2'd0;
   localparam logic [1:0] ADDR_COUNT = 2'd1;
   localparam logic [1:0] ADDR_CLEAR = 2'd2;
   localparam logic [1:0] ADDR_CFG   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t               state_q,   state_d;
   logic [TIMER_W-1:0]   cnt_q,     cnt_d;
   logic                 pending_q, pending_d;
   logic                 done_q,    done_d;
   logic                 overrun_q, overrun_d;
   logic [CNT_W-1:0]     count_q,   count_d;
   logic [DATA_W-1:0]    readdata_d;
   logic                 knn_reset_n_d;
   logic                 busy_d;

   logic                 req_meta_q;
   logic                 req_sync_q;
   logic                 req_hist_q;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic req_rise;
   logic wr_en;
   logic sw_req;
   logic clr_wr;
   logic start;
   logic seq_done;
   logic overrun_set;
   logic unused_wdata;

   assign req_rise = req_sync_q & ~req_hist_q;
   assign wr_en    = chipselect & ~write_n;
   assign sw_req   = wr_en & (address == ADDR_CTRL) & writedata[0];
   assign clr_wr   = wr_en & (address == ADDR_CLEAR);
   assign start    = req_rise | sw_req;

   // Upper write data bits carry no register fields.
   assign unused_wdata = ^writedata[DATA_W-1:2];

   // Two-flop synchroniser on the PIO level plus one history flop for edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_meta_q <= 1'b0;
         req_sync_q <= 1'b0;
         req_hist_q <= 1'b0;
      end else begin
         req_meta_q <= req_in;
         req_sync_q <= req_meta_q;
         req_hist_q <= req_sync_q;
      end
   end

   // ------------------------------------------------------------------------
   // State and datapath registers. Reset lands in ASSERT with a full count so
   // the accelerator gets a complete pulse after every system reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_ASSERT;
         cnt_q       <= RESET_LOAD;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
         readdata    <= '0;
         knn_reset_n <= 1'b0;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         count_q     <= count_d;
         readdata    <= readdata_d;
         knn_reset_n <= knn_reset_n_d;
         busy        <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state, timer and request queue
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pending_d   = pending_q;
      seq_done    = 1'b0;
      overrun_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start || pending_q) begin
               state_d   = ST_ASSERT;
               cnt_d     = RESET_LOAD;
               pending_d = 1'b0;
               // A new request landing while the queued one launches stays queued.
               if (start && pending_q) begin
                  pending_d   = 1'b1;
                  overrun_set = 1'b1;
               end
            end
         end

         ST_ASSERT: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - TIMER_W'(1);
            end
         end

         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d  = ST_IDLE;
               seq_done = 1'b1;
            end else begin
               cnt_d = cnt_q - TIMER_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // One-deep queue for requests arriving mid-sequence.
      if ((state_q != ST_IDLE) && start) begin
         pending_d = 1'b1;
         if (pending_q) begin
            overrun_set = 1'b1;
         end
      end
   end

   // Outputs decoded from next state so they change cleanly on the clock edge.
   always_comb begin
      knn_reset_n_d = (state_d != ST_ASSERT);
      busy_d        = (state_d != ST_IDLE);
   end

   // Sticky status bits and completion counter; a set beats a same-cycle clear.
   always_comb begin
      done_d    = done_q;
      overrun_d = overrun_q;
      count_d   = count_q;

      if (clr_wr && writedata[0]) begin
         done_d = 1'b0;
      end
      if (clr_wr && writedata[1]) begin
         overrun_d = 1'b0;
      end
      if (seq_done) begin
         done_d  = 1'b1;
         count_d = count_q + CNT_W'(1);
      end
      if (overrun_set) begin
         overrun_d = 1'b1;
      end
   end

   // Read mux, sampled every cycle regardless of chipselect.
   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_CTRL:  readdata_d = {29'b0, overrun_q, done_q, busy};
         ADDR_COUNT: readdata_d = DATA_W'(count_q);
         ADDR_CLEAR: readdata_d = '0;
         ADDR_CFG:   readdata_d = {SETTLE_CFG, RESET_CFG};
         default:    readdata_d = '0;
      endcase
   end

   assign irq = done_q;

endmodule
